// File: rtl/ifm_window_read_ctrl.sv
// ==== ifm_window_read_ctrl : scans every KxK window of the banked IFM array, two pixel reads per beat ====
// ==== revision 1.0 ====
`default_nettype none

module ifm_window_read_ctrl #(
  parameter int IFM_SIZE         = 28,
  parameter int KERNEL_SIZE      = 5,
  parameter int STRIDE           = 1,
  parameter int NUMBER_OF_IFM    = 6,
  parameter int NUMBER_OF_UNITS  = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE),
  localparam int c_GROUPS = (NUMBER_OF_IFM + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
  localparam int c_SEL_W  = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        ready_next,
  output logic [c_SEL_W-1:0]          ifm_sel,
  output logic                        ifm_enable_read_A_next,
  output logic                        ifm_enable_read_B_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
  output logic                        data_valid_next,
  output logic                        window_first,
  output logic                        window_last,
  output logic                        busy,
  output logic                        done
);

  localparam int c_OFM    = (IFM_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int c_BEATS  = (KERNEL_SIZE * KERNEL_SIZE + 1) / 2;
  localparam int c_OFM_W  = $clog2(c_OFM + 1);
  localparam int c_BEAT_W = $clog2(c_BEATS + 1);
  localparam int c_K_W    = $clog2(KERNEL_SIZE + 2);
  localparam int c_A_W    = ADDRESS_SIZE_IFM;
  localparam bit c_ODD    = ((KERNEL_SIZE * KERNEL_SIZE) % 2) == 1;

  localparam logic [c_OFM_W-1:0]  c_OFM_LAST  = c_OFM_W'(c_OFM - 1);
  localparam logic [c_OFM_W-1:0]  c_OFM_ONE   = c_OFM_W'(1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(c_BEATS - 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);
  localparam logic [c_SEL_W-1:0]  c_GRP_LAST  = c_SEL_W'(c_GROUPS - 1);
  localparam logic [c_SEL_W-1:0]  c_GRP_ONE   = c_SEL_W'(1);
  localparam logic [c_K_W-1:0]    c_KC_LAST   = c_K_W'(KERNEL_SIZE - 1);
  localparam logic [c_K_W-1:0]    c_K         = c_K_W'(KERNEL_SIZE);
  localparam logic [c_K_W-1:0]    c_KC_TWO    = c_K_W'(2);
  localparam logic [c_A_W-1:0]    c_A_ONE     = c_A_W'(1);
  localparam logic [c_A_W-1:0]    c_A_TWO     = c_A_W'(2);
  localparam logic [c_A_W-1:0]    c_A_WRAP    = c_A_W'(IFM_SIZE + 2 - KERNEL_SIZE);
  localparam logic [c_A_W-1:0]    c_B_WRAP    = c_A_W'(IFM_SIZE + 1 - KERNEL_SIZE);
  localparam logic [c_A_W-1:0]    c_COL_STEP  = c_A_W'(STRIDE);
  localparam logic [c_A_W-1:0]    c_ROW_STEP  = c_A_W'(STRIDE * IFM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_SEL_W-1:0]   r_g, r_sel;
  logic [c_OFM_W-1:0]   r_r, r_c;
  logic [c_BEAT_W-1:0]  r_b;
  logic [c_K_W-1:0]     r_kc;
  logic [c_A_W-1:0]     r_off, r_org, r_row_org;
  logic [c_A_W-1:0]     r_addr_a, r_addr_b;
  logic                 r_en_a, r_en_b, r_iss_first, r_iss_last, r_fin;
  logic                 r_dv, r_wf, r_wl, r_busy, r_done;

  logic [c_K_W-1:0]     w_kc2;
  logic [c_A_W-1:0]     w_off_b, w_addr_a, w_addr_b;
  logic                 w_last_beat, w_last_col, w_last_row, w_last_grp, w_final;
  logic                 w_b_en, w_issue;

  // r_off tracks port A's kernel-relative offset; port B is always the next raster pixel
  assign w_kc2       = r_kc + c_KC_TWO;
  assign w_off_b     = (r_kc == c_KC_LAST) ? r_off + c_B_WRAP : r_off + c_A_ONE;
  assign w_addr_a    = r_org + r_off;
  assign w_addr_b    = r_org + w_off_b;
  assign w_last_beat = (r_b == c_BEAT_LAST);
  assign w_last_col  = (r_c == c_OFM_LAST);
  assign w_last_row  = (r_r == c_OFM_LAST);
  assign w_last_grp  = (r_g == c_GRP_LAST);
  assign w_final     = w_last_beat && w_last_col && w_last_row && w_last_grp;
  assign w_b_en      = !(c_ODD && w_last_beat);
  // Counters sit at zero in IDLE, so the start edge can already issue beat 0
  assign w_issue     = ready_next && (((r_state == S_IDLE) && start) ||
                                      ((r_state == S_RUN) && !r_fin));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_sel       <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_b         <= '0;
      r_kc        <= '0;
      r_off       <= '0;
      r_org       <= '0;
      r_row_org   <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_en_a      <= 1'b0;
      r_en_b      <= 1'b0;
      r_iss_first <= 1'b0;
      r_iss_last  <= 1'b0;
      r_fin       <= 1'b0;
      r_dv        <= 1'b0;
      r_wf        <= 1'b0;
      r_wl        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_en_a <= 1'b0;
      r_en_b <= 1'b0;
      r_done <= 1'b0;
      r_dv   <= r_en_a;
      r_wf   <= r_en_a && r_iss_first;
      r_wl   <= r_en_a && r_iss_last;

      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
          r_sel   <= '0;
          r_fin   <= 1'b0;
        end
        S_RUN: if (r_fin) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        r_en_a      <= 1'b1;
        r_en_b      <= w_b_en;
        r_addr_a    <= w_addr_a;
        r_addr_b    <= w_b_en ? w_addr_b : '0;
        r_sel       <= r_g;
        r_iss_first <= (r_b == '0);
        r_iss_last  <= w_last_beat;
        r_fin       <= w_final;
        if (w_last_beat) begin
          r_b   <= '0;
          r_kc  <= '0;
          r_off <= '0;
          if (w_last_col) begin
            r_c <= '0;
            if (w_last_row) begin
              r_r       <= '0;
              r_row_org <= '0;
              r_org     <= '0;
              r_g       <= w_last_grp ? '0 : r_g + c_GRP_ONE;
            end else begin
              r_r       <= r_r + c_OFM_ONE;
              r_row_org <= r_row_org + c_ROW_STEP;
              r_org     <= r_row_org + c_ROW_STEP;
            end
          end else begin
            r_c   <= r_c + c_OFM_ONE;
            r_org <= r_org + c_COL_STEP;
          end
        end else begin
          r_b <= r_b + c_BEAT_ONE;
          if (w_kc2 >= c_K) begin
            r_kc  <= w_kc2 - c_K;
            r_off <= r_off + c_A_WRAP;
          end else begin
            r_kc  <= w_kc2;
            r_off <= r_off + c_A_TWO;
          end
        end
      end
    end
  end

  assign ifm_sel                 = r_sel;
  assign ifm_enable_read_A_next  = r_en_a;
  assign ifm_enable_read_B_next  = r_en_b;
  assign ifm_address_read_A_next = r_addr_a;
  assign ifm_address_read_B_next = r_addr_b;
  assign data_valid_next         = r_dv;
  assign window_first            = r_wf;
  assign window_last             = r_wl;
  assign busy                    = r_busy;
  assign done                    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ifm_window_read_ctrl.sv
// ==== tb_ifm_window_read_ctrl : directed bench with a div/mod address model for ifm_window_read_ctrl ====
// ==== revision 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module tb_ifm_window_read_ctrl;

  localparam int IFM   = 28;
  localparam int K     = 5;
  localparam int OFMS  = 24;
  localparam int BEATS = 13;
  localparam int WIN   = OFMS * OFMS;
  localparam int TOTAL = 2 * WIN * BEATS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       ready_next = 1'b0;
  logic       ifm_sel;
  logic       en_a, en_b;
  logic [9:0] addr_a, addr_b;
  logic       dv, wf, wl, busy, done;
  logic [31:0] w_obs;

  int checks = 0;
  int errors = 0;

  // Hand-computed beats: index, A address, B address, B enable, ifm_sel
  int dir_beat [9] = '{0, 2, 5, 12, 13, 312, 7475, 7487, 7488};
  int dir_a    [9] = '{0, 4, 56, 116, 1, 28, 667, 783, 0};
  int dir_b    [9] = '{1, 28, 57, 0, 2, 29, 668, 0, 1};
  int dir_eb   [9] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
  int dir_sel  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  ifm_window_read_ctrl dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .ready_next              (ready_next),
    .ifm_sel                 (ifm_sel),
    .ifm_enable_read_A_next  (en_a),
    .ifm_enable_read_B_next  (en_b),
    .ifm_address_read_A_next (addr_a),
    .ifm_address_read_B_next (addr_b),
    .data_valid_next         (dv),
    .window_first            (wf),
    .window_last             (wl),
    .busy                    (busy),
    .done                    (done)
  );

  assign w_obs = {4'b0, ifm_sel, en_a, en_b, addr_a, addr_b, dv, wf, wl, busy, done};

  function automatic logic [31:0] pack(input logic s, input logic a, input logic b,
                                       input logic [9:0] aa, input logic [9:0] bb,
                                       input logic d, input logic f, input logic l,
                                       input logic bz, input logic dn);
    return {4'b0, s, a, b, aa, bb, d, f, l, bz, dn};
  endfunction

  function automatic int exp_addr(input int k, input int port);
    int w, b, rem, r, c, p;
    w   = k / BEATS;
    b   = k % BEATS;
    rem = w % WIN;
    r   = rem / OFMS;
    c   = rem % OFMS;
    p   = 2 * b + port;
    if (p >= K * K) return 0;
    return (r + p / K) * IFM + c + p % K;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input int stall_beat, input int stall_len,
                          input int poke_beat, input int abort_beat);
    int k = 0;
    int cur = 0;
    int prev_beat = 0;
    int stall_left;
    bit prev_en = 1'b0;
    bit issued;
    bit rdy;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    logic [9:0] la = '0;
    logic [9:0] lb = '0;
    logic ls = 1'b0;
    logic exp_enb, exp_done;
    stall_left = stall_len;
    for (int cyc = 0; cyc < 20000 && !fin && !aborted; cyc++) begin
      if (abort_beat >= 0 && k == abort_beat) begin
        aborted = 1'b1;
      end else begin
        rdy = !(k == stall_beat && stall_left > 0);
        if (!rdy) stall_left--;
        ready_next = rdy;
        start = (cyc == 0) || (k == poke_beat);
        tick();
        issued  = rdy && (k < TOTAL);
        exp_enb = 1'b0;
        if (issued) begin
          cur = k;
          k++;
          la = 10'(exp_addr(cur, 0));
          lb = 10'(exp_addr(cur, 1));
          ls = 1'((cur / BEATS) / WIN);
          exp_enb = (2 * (cur % BEATS) + 1) < K * K;
          for (int i = 0; i < 9; i++) begin
            if (cur == dir_beat[i]) begin
              chk("dir_addr_a", 32'(addr_a), dir_a[i]);
              chk("dir_addr_b", 32'(addr_b), dir_b[i]);
              chk("dir_en_b", 32'(en_b), dir_eb[i]);
              chk("dir_sel", 32'(ifm_sel), dir_sel[i]);
            end
          end
        end
        exp_done = prev_en && (prev_beat == TOTAL - 1);
        chk("cycle", w_obs, pack(ls, issued, exp_enb, la, lb, prev_en,
                                 prev_en && (prev_beat % BEATS == 0),
                                 prev_en && (prev_beat % BEATS == BEATS - 1),
                                 !exp_done, exp_done));
        prev_en   = issued;
        prev_beat = cur;
        fin       = exp_done;
      end
    end
    start = 1'b0;
    if (abort_beat < 0) begin
      chk("scan_completed", 32'(fin), 32'd1);
      tick();
      chk("post_done", w_obs, pack(ls, 1'b0, 1'b0, la, lb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", w_obs, 32'd0);

    rst_n = 1'b1;
    ready_next = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_no_start", w_obs, 32'd0);
    end

    // Full scan without stalls; start pulsed again while running
    run_scan(-1, 0, 100, -1);
    // Second scan straight after done, stalled three cycles ahead of beat 5
    run_scan(5, 3, -1, -1);
    // Third scan interrupted by reset inside group 1
    run_scan(-1, 0, -1, 8000);
    rst_n = 1'b0;
    #2;
    chk("async_reset", w_obs, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_hold", w_obs, 32'd0);
    tick();
    chk("after_reset_idle", w_obs, 32'd0);
    run_scan(-1, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
